// File: rtl/request_arbiter_8.sv
// Eight-way arbiter for a shared resource: one grant at a time, fixed or rotating priority,
// a hold-time limit per grant and an idle turnaround gap between grants.
module request_arbiter_8 #(
  parameter int MAX_HOLD    = 16,
  parameter int GAP_CYCLES  = 1,
  parameter int ROUND_ROBIN = 0
) (
  input  logic       Clock_In,
  input  logic       Reset_N_In,
  input  logic       Enable_In,
  input  logic [7:0] Request_In,
  output logic [7:0] Grant_Out,
  output logic [2:0] Grant_Index_Out,
  output logic       Grant_Valid_Out,
  output logic       Timeout_Out,
  output logic [1:0] state_dbg
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [7:0]        grant_nxt;
  logic [2:0]        index_nxt;
  logic              valid_nxt;
  logic              timeout_nxt;

  logic [2:0] search_start;
  logic [2:0] winner;
  logic       can_arbitrate;
  logic       issue;
  logic       release_req;
  logic       expire;

  assign state_dbg = state;

  // Grant_Index_Out doubles as the last winner: it only changes when a grant is issued.
  assign search_start = (ROUND_ROBIN != 0) ? Grant_Index_Out - 3'd1 : 3'd7;

  // Downward search from search_start with wrap; the last assignment (k=0) has top priority.
  always_comb begin
    winner = search_start;
    for (int k = 7; k >= 0; k--) begin
      if (Request_In[search_start - 3'(k)]) winner = search_start - 3'(k);
    end
  end

  // The edge that ends the final gap cycle arbitrates just like an IDLE edge.
  assign can_arbitrate = (state == ST_IDLE) ||
                         ((state == ST_GAP) && (gap_cnt == GAP_W'(GAP_CYCLES)));
  assign issue         = can_arbitrate && Enable_In && (Request_In != 8'h00);
  assign release_req   = (state == ST_GRANT) && !Request_In[Grant_Index_Out];
  assign expire        = (state == ST_GRANT) && Request_In[Grant_Index_Out] &&
                         (hold_cnt == HOLD_W'(MAX_HOLD));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    case (state)
      ST_GRANT: begin
        if (release_req || expire) begin
          state_nxt = ST_GAP;
          hold_nxt  = '0;
          gap_nxt   = GAP_W'(1);
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_IDLE, ST_GAP: begin
        if (!can_arbitrate) begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end else if (issue) begin
          state_nxt = ST_GRANT;
          hold_nxt  = HOLD_W'(1);
          gap_nxt   = '0;
        end else begin
          state_nxt = ST_IDLE;
          gap_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hold_nxt  = '0;
        gap_nxt   = '0;
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    grant_nxt   = 8'h00;
    index_nxt   = Grant_Index_Out;
    valid_nxt   = 1'b0;
    timeout_nxt = expire;
    if (issue) begin
      grant_nxt = 8'h01 << winner;
      index_nxt = winner;
      valid_nxt = 1'b1;
    end else if ((state == ST_GRANT) && !release_req && !expire) begin
      grant_nxt = Grant_Out;
      valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state           <= ST_IDLE;
      hold_cnt        <= '0;
      gap_cnt         <= '0;
      Grant_Out       <= 8'h00;
      Grant_Index_Out <= 3'd0;
      Grant_Valid_Out <= 1'b0;
      Timeout_Out     <= 1'b0;
    end else begin
      state           <= state_nxt;
      hold_cnt        <= hold_nxt;
      gap_cnt         <= gap_nxt;
      Grant_Out       <= grant_nxt;
      Grant_Index_Out <= index_nxt;
      Grant_Valid_Out <= valid_nxt;
      Timeout_Out     <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_request_arbiter_8.sv
// Bench for request_arbiter_8: a fixed-priority and a rotating-priority instance driven side by
// side, checked every cycle against an owner/hold/gap model plus directed constant checks.
module tb_request_arbiter_8;

  localparam int MAXH = 4;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       en_f, en_r;
  logic [7:0] req_f, req_r;
  logic [7:0] gnt_f, gnt_r;
  logic [2:0] idx_f, idx_r;
  logic       val_f, val_r, to_f, to_r;
  logic [1:0] st_f, st_r;

  request_arbiter_8 #(.MAX_HOLD(MAXH), .GAP_CYCLES(1), .ROUND_ROBIN(0)) u_fix (
    .Clock_In(clk), .Reset_N_In(rst_n), .Enable_In(en_f), .Request_In(req_f),
    .Grant_Out(gnt_f), .Grant_Index_Out(idx_f), .Grant_Valid_Out(val_f),
    .Timeout_Out(to_f), .state_dbg(st_f));

  request_arbiter_8 #(.MAX_HOLD(MAXH), .GAP_CYCLES(2), .ROUND_ROBIN(1)) u_rr (
    .Clock_In(clk), .Reset_N_In(rst_n), .Enable_In(en_r), .Request_In(req_r),
    .Grant_Out(gnt_r), .Grant_Index_Out(idx_r), .Grant_Valid_Out(val_r),
    .Timeout_Out(to_r), .state_dbg(st_r));

  // Reference model: who owns the resource, for how long, and how many idle cycles remain
  int gap_cfg [2] = '{1, 2};
  int rr_cfg  [2] = '{0, 1};
  int m_owner [2];
  int m_held  [2];
  int m_gap   [2];
  int m_idx   [2];
  int m_to    [2];

  int n_assert = 0;
  int n_fail   = 0;
  logic [12:0] exp_q[$];

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start - k + 8) % 8]) return (start - k + 8) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_held[d] = 0; m_gap[d] = 0; m_idx[d] = 0; m_to[d] = 0;
    end
  endtask

  task automatic model_edge(input int d, input logic e, input logic [7:0] r);
    m_to[d] = 0;
    if (m_owner[d] >= 0) begin
      if (!r[m_owner[d]]) begin
        m_owner[d] = -1; m_gap[d] = gap_cfg[d];
      end else if (m_held[d] == MAXH) begin
        m_owner[d] = -1; m_gap[d] = gap_cfg[d]; m_to[d] = 1;
      end else begin
        m_held[d]++;
      end
    end else if (m_gap[d] > 1) begin
      m_gap[d]--;
    end else begin
      m_gap[d] = 0;
      if (e && r != 8'h00) begin
        m_owner[d] = pick(r, (rr_cfg[d] != 0) ? (m_idx[d] + 7) % 8 : 7);
        m_held[d]  = 1;
        m_idx[d]   = m_owner[d];
      end
    end
  endtask

  function automatic logic [12:0] exp_vec(input int d);
    logic [7:0] g;
    g = (m_owner[d] >= 0) ? 8'(1 << m_owner[d]) : 8'h00;
    return {1'(m_to[d]), 1'(m_owner[d] >= 0), 3'(m_idx[d]), g};
  endfunction

  function automatic logic [12:0] obs(input int d);
    return (d == 0) ? {to_f, val_f, idx_f, gnt_f} : {to_r, val_r, idx_r, gnt_r};
  endfunction

  task automatic check(input string tag, input logic [12:0] o, input logic [12:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Driver: one clock edge, model update at the edge, outputs checked on the falling edge
  task automatic step(input string tag);
    @(posedge clk);
    model_edge(0, en_f, req_f);
    model_edge(1, en_r, req_r);
    exp_q.push_back(exp_vec(0));
    exp_q.push_back(exp_vec(1));
    @(negedge clk);
    check({tag, "_fix"}, obs(0), exp_q.pop_front());
    check({tag, "_rr"}, obs(1), exp_q.pop_front());
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  function automatic logic [7:0] next_req(input logic [7:0] r, input int owner);
    logic [7:0] n;
    n = r;
    for (int i = 0; i < 8; i++) begin
      if (i == owner) n[i] = ($urandom_range(0, 2) != 0);
      else if (!r[i]) n[i] = ($urandom_range(0, 4) == 0);
    end
    return n;
  endfunction

  int k_order;

  initial begin
    rst_n = 1'b0; en_f = 1'b0; en_r = 1'b0; req_f = 8'h00; req_r = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_fix", obs(0), 13'h0000);
    check("reset_rr", obs(1), 13'h0000);
    rst_n = 1'b1;

    // Async reset in the middle of a grant, then a fresh grant on requester 0
    en_f = 1'b1; req_f = 8'h10;
    steps("t1_pre", 2);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("t1_async_fix", obs(0), 13'h0000);
    check("t1_async_rr", obs(1), 13'h0000);
    @(negedge clk);
    rst_n = 1'b1; req_f = 8'h01;
    step("t1_grant");
    check("t1_g01", obs(0), {1'b0, 1'b1, 3'd0, 8'h01});
    req_f = 8'h00;
    steps("t1_idle", 3);

    // Fixed priority, release and one-cycle gap
    req_f = 8'h24;
    step("t2_grant");
    check("t2_g20", obs(0), {1'b0, 1'b1, 3'd5, 8'h20});
    req_f = 8'h04;
    step("t2_gap");
    check("t2_gap0", obs(0), {1'b0, 1'b0, 3'd5, 8'h00});
    step("t2_next");
    check("t2_g04", obs(0), {1'b0, 1'b1, 3'd2, 8'h04});
    req_f = 8'h00;
    steps("t2_idle", 3);

    // Hold limit, then simultaneous drop at the limit
    req_f = 8'h80;
    steps("t4_hold", 4);
    check("t4_last_grant", obs(0), {1'b0, 1'b1, 3'd7, 8'h80});
    step("t4_timeout");
    check("t4_to_pulse", obs(0), {1'b1, 1'b0, 3'd7, 8'h00});
    step("t4_regrant");
    check("t4_regrant80", obs(0), {1'b0, 1'b1, 3'd7, 8'h80});
    steps("t4_hold2", 3);
    req_f = 8'h00;
    step("t4_drop_at_limit");
    check("t4_no_timeout", obs(0), {1'b0, 1'b0, 3'd7, 8'h00});
    steps("t4_idle", 3);

    // No preemption, enable gating
    req_f = 8'h04;
    step("t5_grant2");
    req_f = 8'h84;
    steps("t5_keep", 2);
    check("t5_no_preempt", obs(0), {1'b0, 1'b1, 3'd2, 8'h04});
    req_f = 8'h00;
    steps("t5_rel", 2);
    en_f = 1'b0; req_f = 8'hFF;
    steps("t5_disabled", 3);
    check("t5_no_grant", obs(0), {1'b0, 1'b0, 3'd2, 8'h00});
    en_f = 1'b1;
    step("t5_enable");
    check("t5_g80", obs(0), {1'b0, 1'b1, 3'd7, 8'h80});
    req_f = 8'h00;
    steps("t5_idle", 3);

    // Rotating priority: everyone requests, each winner lets go after two cycles
    en_r = 1'b1; req_r = 8'hFF; k_order = 0;
    for (int c = 0; c < 200 && k_order < 9; c++) begin
      step("t3");
      if (m_owner[1] >= 0 && m_held[1] == 1) begin
        check("t3_order", 13'(idx_r), 13'((15 - k_order) % 8));
        k_order++;
      end
      if (m_owner[1] >= 0 && m_held[1] == 2) req_r = 8'hFF & ~8'(1 << m_owner[1]);
      else req_r = 8'hFF;
    end
    check("t3_count", 13'(k_order), 13'd9);
    req_r = 8'h00;
    steps("t3_idle", 4);

    // Random traffic on both instances
    for (int c = 0; c < 500; c++) begin
      en_f  = ($urandom_range(0, 9) != 0);
      en_r  = ($urandom_range(0, 9) != 0);
      req_f = next_req(req_f, m_owner[0]);
      req_r = next_req(req_r, m_owner[1]);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
